// File: rtl/aes_hs_bridge.sv
// Four-phase handshake bridge between the Nios II signal/data PIOs and the AES core:
// collects input bytes, starts the core, and returns result bytes one at a time.
module aes_hs_bridge #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       to_hw_sig,
  input  logic [7:0]       to_hw_port,
  output logic [1:0]       to_sw_sig,
  output logic [7:0]       to_sw_port,
  output logic             core_start,
  output logic [WIDTH-1:0] core_din,
  input  logic [WIDTH-1:0] core_dout,
  input  logic             core_done
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] CmdIdle  = 2'b00;
  localparam logic [1:0] CmdWrite = 2'b01;
  localparam logic [1:0] CmdRead  = 2'b10;
  localparam logic [1:0] CmdStart = 2'b11;

  typedef enum logic [2:0] {StIdle, StWrAck, StRdAck, StRun, StDoneAck} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
  logic [1:0]       sig_q, sig_d;
  logic [7:0]       port_q, port_d;
  logic             start_q, start_d;
  logic [7:0]       rd_byte;

  function automatic logic [CW-1:0] inc_mod(input logic [CW-1:0] c);
    return (c == CW'(NB - 1)) ? '0 : c + 1'b1;
  endfunction

  // Byte 0 is the most significant byte of the result.
  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (rd_cnt_q == CW'(i)) rd_byte = result_q[WIDTH-1-8*i -: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    result_d = result_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    sig_d    = sig_q;
    port_d   = port_q;
    start_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        unique case (to_hw_sig)
          CmdWrite: begin
            din_d    = (din_q << 8) | WIDTH'(to_hw_port);
            wr_cnt_d = inc_mod(wr_cnt_q);
            sig_d    = CmdWrite;
            state_d  = StWrAck;
          end
          CmdRead: begin
            port_d   = rd_byte;
            rd_cnt_d = inc_mod(rd_cnt_q);
            sig_d    = CmdRead;
            state_d  = StRdAck;
          end
          CmdStart: begin
            start_d  = 1'b1;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            state_d  = StRun;
          end
          CmdIdle: ;
        endcase
      end
      StWrAck, StRdAck, StDoneAck: begin
        // Acks hold until software drops back to idle; other commands are ignored.
        if (to_hw_sig == CmdIdle) begin
          sig_d   = CmdIdle;
          state_d = StIdle;
        end
      end
      StRun: begin
        if (core_done) begin
          result_d = core_dout;
          sig_d    = CmdStart;
          state_d  = StDoneAck;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      din_q    <= '0;
      result_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      sig_q    <= '0;
      port_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      result_q <= result_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      sig_q    <= sig_d;
      port_q   <= port_d;
      start_q  <= start_d;
    end
  end

  assign to_sw_sig  = sig_q;
  assign to_sw_port = port_q;
  assign core_start = start_q;
  assign core_din   = din_q;

endmodule

// File: tb/tb_aes_hs_bridge.sv
// Self-checking bench for aes_hs_bridge: table-driven write/read vectors, hand-written
// corner sequences, and random handshake traffic checked against a transaction-level model.
module tb_aes_hs_bridge;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   to_hw_sig = '0;
  logic [7:0]   to_hw_port = '0;
  logic [1:0]   to_sw_sig;
  logic [7:0]   to_sw_port;
  logic         core_start;
  logic [127:0] core_din;
  logic [127:0] core_dout = '0;
  logic         core_done = 1'b0;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: written block, latched result, read index, last returned byte.
  logic [127:0] mdin = '0;
  logic [127:0] mres = '0;
  int           mrd = 0;
  logic [7:0]   mport = '0;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] data;
    logic [1:0] exp_sig;
    logic [7:0] exp_port;
  } vec_t;

  vec_t       vecs[33];
  logic [7:0] rd_exp[17];

  aes_hs_bridge #(.WIDTH(128)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .to_hw_sig (to_hw_sig),
    .to_hw_port(to_hw_port),
    .to_sw_sig (to_sw_sig),
    .to_sw_port(to_sw_port),
    .core_start(core_start),
    .core_din  (core_din),
    .core_dout (core_dout),
    .core_done (core_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int k);
    return mres[127-8*k -: 8];
  endfunction

  task automatic chk_zero(input string name);
    chk({name, "_sig"}, to_sw_sig, 0);
    chk({name, "_port"}, to_sw_port, 0);
    chk({name, "_start"}, core_start, 0);
    chk({name, "_din"}, core_din, 0);
  endtask

  // One full command/release handshake.
  task automatic hs(input logic [1:0] cmd, input logic [7:0] data, input logic [1:0] esig,
                    input logic [7:0] eport);
    to_hw_sig  = cmd;
    to_hw_port = data;
    cycle();
    if (cmd == 2'b01) mdin = {mdin[119:0], data};
    if (cmd == 2'b10) begin
      mrd   = (mrd + 1) % 16;
      mport = eport;
    end
    chk("ack_sig", to_sw_sig, esig);
    chk("ack_port", to_sw_port, eport);
    chk("ack_din", core_din, mdin);
    chk("ack_start", core_start, 0);
    to_hw_sig  = 2'b00;
    to_hw_port = 8'($urandom);
    cycle();
    chk("rel_sig", to_sw_sig, 0);
    chk("rel_port", to_sw_port, eport);
  endtask

  // Start, core_done at the d-th edge after the start edge (pre: done already high at start).
  task automatic run(input logic [127:0] dout, input int d, input bit pre);
    core_dout = dout;
    core_done = pre;
    to_hw_sig = 2'b11;
    cycle();
    mrd = 0;
    chk("run_start", core_start, 1);
    chk("run_sig0", to_sw_sig, 0);
    chk("run_din0", core_din, mdin);
    for (int k = 1; k < d; k++) begin
      core_done  = 1'b0;
      to_hw_sig  = 2'($urandom);
      to_hw_port = 8'($urandom);
      cycle();
      chk("run_start_lo", core_start, 0);
      chk("run_wait_sig", to_sw_sig, 0);
      chk("run_wait_din", core_din, mdin);
    end
    core_done  = 1'b1;
    to_hw_sig  = 2'($urandom);
    to_hw_port = 8'($urandom);
    cycle();
    mres = dout;
    chk("done_sig", to_sw_sig, 2'b11);
    chk("done_start", core_start, 0);
    core_done  = 1'b0;
    to_hw_sig  = 2'($urandom_range(1, 3));
    cycle();
    chk("done_hold", to_sw_sig, 2'b11);
    chk("done_din", core_din, mdin);
    to_hw_sig = 2'b00;
    cycle();
    chk("done_rel", to_sw_sig, 0);
  endtask

  initial begin
    rd_exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
               8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hDE};
    for (int i = 0; i < 16; i++) vecs[i] = '{2'b01, 8'(i), 2'b01, 8'h00};
    for (int i = 0; i < 17; i++) vecs[16+i] = '{2'b10, 8'h00, 2'b10, rd_exp[i]};

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      to_hw_sig  = 2'($urandom);
      to_hw_port = 8'($urandom);
      core_done  = 1'($urandom);
      core_dout  = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      chk_zero("rst");
    end
    to_hw_sig = 2'b00;
    core_done = 1'b0;
    reset_n   = 1'b1;
    cycle();
    chk_zero("post_rst");
    cycle();
    chk("post_rst_sig2", to_sw_sig, 0);

    // Table: 16 writes, run, 17 reads with wrap.
    for (int i = 0; i < 33; i++) begin
      if (i == 16) begin
        chk("block", core_din, 128'h000102030405060708090A0B0C0D0E0F);
        run(128'hDEADBEEF_00112233_44556677_8899AABB, 5, 1'b0);
      end
      hs(vecs[i].cmd, vecs[i].data, vecs[i].exp_sig, vecs[i].exp_port);
    end

    // core_done already high when RUN is entered.
    run(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 1, 1'b1);

    // 01 changed directly to 10: stays in write ack, one byte shifted, no read.
    to_hw_sig  = 2'b01;
    to_hw_port = 8'hA5;
    cycle();
    mdin = {mdin[119:0], 8'hA5};
    chk("abuse_wr_sig", to_sw_sig, 2'b01);
    to_hw_sig = 2'b10;
    cycle();
    chk("abuse_rd_sig", to_sw_sig, 2'b01);
    chk("abuse_rd_port", to_sw_port, mport);
    to_hw_sig  = 2'b01;
    to_hw_port = 8'h5A;
    cycle();
    chk("abuse_din", core_din, mdin);
    to_hw_sig = 2'b00;
    cycle();
    chk("abuse_rel", to_sw_sig, 0);
    hs(2'b10, 8'h00, 2'b10, mbyte(mrd));

    // Reset in RUN truncates the start pulse; later core_done in IDLE is ignored.
    to_hw_sig = 2'b11;
    cycle();
    chk("rrun_start", core_start, 1);
    reset_n = 1'b0;
    #1;
    chk_zero("rrun");
    mdin = '0; mres = '0; mrd = 0; mport = '0;
    to_hw_sig = 2'b00;
    cycle();
    reset_n   = 1'b1;
    core_done = 1'b1;
    core_dout = {4{32'hCAFEF00D}};
    cycle();
    chk("rrun_sig", to_sw_sig, 0);
    chk("rrun_din", core_din, 0);
    core_done = 1'b0;
    hs(2'b10, 8'h00, 2'b10, 8'h00);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      int sel = $urandom_range(0, 99);
      if (sel < 50) hs(2'b01, 8'($urandom), 2'b01, mport);
      else if (sel < 85) hs(2'b10, 8'($urandom), 2'b10, mbyte(mrd));
      else run({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 6), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_hs_bridge.md
# aes_hs_bridge

Downstream consumer of the 2-bit software-to-hardware signal PIO and its companion 8-bit data PIO. It runs a four-phase handshake with software to move bytes into a 128-bit block buffer, start the AES core, and return the core's 128-bit result one byte at a time. It drives the return signal/data PIOs read by the Nios II.

## Interface
- WIDTH, 128: block width in bits; must be a multiple of 8. NB = WIDTH/8 bytes.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- to_hw_sig  in  2  command from the software PIO: 00 idle, 01 write byte, 10 read byte, 11 start.
- to_hw_port  in  8  data byte from the software PIO; valid while to_hw_sig = 01.
- to_sw_sig  out  2  acknowledge to software; mirrors the accepted command during its ack phase.
- to_sw_port  out  8  result byte returned to software.
- core_start  out  1  single-cycle start pulse to the AES core.
- core_din  out  WIDTH  assembled input block.
- core_dout  in  WIDTH  core result; sampled when core_done = 1.
- core_done  in  1  core completion; level or pulse; only sampled in RUN.

## Operation
- Reset: all outputs 0; state IDLE; wr_cnt = rd_cnt = 0; result register = 0.
- States: IDLE, WR_ACK, RD_ACK, RUN, DONE_ACK.
- IDLE, to_hw_sig = 01:
  - core_din <= {core_din[WIDTH-9:0], to_hw_port}, so the first byte written ends up in the MSB byte.
  - wr_cnt increments mod NB.
  - to_sw_sig <= 01; go to WR_ACK.
- IDLE, to_hw_sig = 10:
  - to_sw_port <= result byte rd_cnt, where byte 0 = result[WIDTH-1:WIDTH-8].
  - rd_cnt increments mod NB, wrapping from NB-1 to 0.
  - to_sw_sig <= 10; go to RD_ACK.
- IDLE, to_hw_sig = 11:
  - core_start <= 1 for exactly one cycle; wr_cnt and rd_cnt cleared.
  - to_sw_sig stays 00; go to RUN.
- IDLE, to_hw_sig = 00: no action.
- WR_ACK / RD_ACK:
  - Hold to_sw_sig until to_hw_sig = 00, then to_sw_sig <= 00 and go to IDLE.
  - Any non-00 command, including a direct change 01->10, is ignored; no second byte is transferred without an intervening 00.
- RUN:
  - Wait for core_done = 1; to_hw_sig is ignored, including 00 and new commands.
  - On core_done: result <= core_dout; to_sw_sig <= 11; go to DONE_ACK.
- DONE_ACK:
  - Hold to_sw_sig = 11 until to_hw_sig = 00, then to_sw_sig <= 00 and go to IDLE.
- core_din is held stable from the start command through DONE_ACK. Writes are only possible in IDLE.
- Writing more than NB bytes keeps shifting: the last NB bytes written form the block.
- Reading before any run returns 0s.
- Reset mid-operation: immediate return to reset values. A core_start pulse in flight is truncated.

## Timing
- Inputs are on the same clk domain; no synchronizers.
- All outputs are registered.
- Command sampled at edge N: to_sw_sig and to_sw_port valid after edge N, with the byte shift on the same edge. Ack latency is 1 cycle.
- Release: to_hw_sig = 00 sampled at edge M clears to_sw_sig after edge M. The next command is accepted at edge M+1 at the earliest.
- core_start is high exactly during the cycle after the start command is sampled.
- core_done is sampled from the first RUN cycle. If core_done is already high on entry to RUN, DONE_ACK is reached one cycle later.
- Minimum full handshake is 2 cycles: command sampled, then 00 sampled.

## Test plan
- Reset: hold reset_n = 0 with random inputs -> all outputs 0, state IDLE. Release -> outputs stay 0 while to_hw_sig = 00.
- Write 16 bytes 0x00..0x0F, each with 01/00 handshake:
  - each 01 -> to_sw_sig = 01 one cycle later, then 00 after release;
  - core_din = 128'h000102030405060708090A0B0C0D0E0F.
- Start with core_done tied to a 5-cycle delayed pulse and core_dout = 128'hDEADBEEF_00112233_44556677_8899AABB:
  - core_start high exactly one cycle;
  - to_sw_sig = 11 one cycle after core_done, held until 00.
- 17 reads after that run:
  - to_sw_port sequence DE, AD, BE, EF, 00, 11, ..., BB;
  - 17th read wraps to DE;
  - to_sw_sig = 10 during each ack.
- Protocol abuse:
  - 01 changed directly to 10 without 00 -> stays in WR_ACK, one byte shifted, no read.
  - Commands during RUN -> ignored.
- Assert reset_n = 0 in RUN, then release -> to_sw_sig = 00 and core_din = 0. A later core_done in IDLE has no effect.
